// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four clients and the rr_arbiter4 arbiter.
// The master side is the client group; the slave side is the arbiter.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic       mode;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done, mode,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  req, done, mode,
        output grant, grant_id, busy, timeout
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way arbiter with fixed-priority or round-robin selection. It holds the grant until done,
// withdrawal or a hold-time limit, and leaves one dead cycle between grants.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter4_if.slave  arb
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic       HoldEn    = (MAX_HOLD != 0);
    localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;
    logic       timeout_q, timeout_d;

    logic [1:0] winner;
    logic [1:0] scan_idx;
    logic       hold_hit;
    logic       withdrawn;

    // Winner selection. Loops run so the last match wins: ascending for highest-index priority,
    // descending offsets so the slot closest to ptr wins in round-robin.
    always_comb begin
        winner   = 2'd0;
        scan_idx = 2'd0;
        if (arb.mode) begin
            for (int i = 0; i < 4; i++) begin
                if (arb.req[i]) winner = 2'(i);
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                scan_idx = ptr_q + 2'(k);
                if (arb.req[scan_idx]) winner = scan_idx;
            end
        end
    end

    assign hold_hit  = HoldEn && (cnt_q == HoldLimit);
    assign withdrawn = !arb.req[owner_q];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|arb.req) begin
                    state_d = StBusy;
                    owner_d = winner;
                    cnt_d   = 8'd1;
                    grant_d = 4'b0001 << winner;
                end
            end
            StBusy: begin
                if (arb.done || withdrawn || hold_hit) begin
                    state_d   = StIdle;
                    owner_d   = 2'd0;
                    ptr_d     = owner_q + 2'd1;
                    cnt_d     = 8'd0;
                    grant_d   = 4'b0000;
                    // Only a pure limit expiry counts as a timeout.
                    timeout_d = !arb.done && !withdrawn;
                end else if (cnt_q != 8'hff) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign arb.grant    = grant_q;
    assign arb.grant_id = owner_q;
    assign arb.busy     = (state_q == StBusy);
    assign arb.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4 (MAX_HOLD=4): directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the arbitration rules.
module tb_rr_arbiter4;

    localparam int unsigned HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    rr_arbiter4_if arb_if ();

    rr_arbiter4 #(.MAX_HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_if)
    );

    always #5 clk = ~clk;

    // Model: owner index (-1 = idle), cycles held so far, rotation start point, timeout pulse.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_ptr   = 0;
    logic m_to    = 1'b0;

    function automatic int pick(logic [3:0] r, logic m, int p);
        if (m) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_held  <= 0;
            m_ptr   <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_owner < 0) begin
                if (arb_if.req != 4'b0) begin
                    m_owner <= pick(arb_if.req, arb_if.mode, m_ptr);
                    m_held  <= 1;
                end
            end else if (arb_if.done || !arb_if.req[m_owner] ||
                         (HOLD != 0 && m_held == int'(HOLD))) begin
                m_to    <= !arb_if.done && arb_if.req[m_owner];
                m_ptr   <= (m_owner + 1) % 4;
                m_owner <= -1;
                m_held  <= 0;
            end else begin
                m_held <= (m_held < 255) ? m_held + 1 : 255;
            end
        end
    end

    function automatic logic [7:0] outs();
        return {arb_if.grant, arb_if.grant_id, arb_if.busy, arb_if.timeout};
    endfunction

    function automatic logic [7:0] model_exp();
        logic [7:0] e;
        e = 8'b0;
        if (m_owner >= 0) begin
            e[7:4] = 4'b0001 << m_owner;
            e[3:2] = 2'(m_owner);
            e[1]   = 1'b1;
        end
        e[0] = m_to;
        return e;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got grant/id/busy/to=%b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) check("model", outs(), model_exp());
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(string name, logic [7:0] exp);
        int n = 0;
        while (!arb_if.busy && n < 8) begin
            tick();
            n++;
        end
        check(name, outs(), exp);
    endtask

    initial begin
        arb_if.req  = 4'b0;
        arb_if.done = 1'b0;
        arb_if.mode = 1'b0;
        #1 check("reset", outs(), 8'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("idle_no_req", outs(), 8'b0);

        // Round-robin basic grant, release and dead cycle.
        arb_if.req = 4'b0101;
        tick();
        check("s1_first", outs(), {4'b0001, 2'd0, 1'b1, 1'b0});
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        check("s1_dead", outs(), 8'b0);
        tick();
        check("s1_second", outs(), {4'b0100, 2'd2, 1'b1, 1'b0});
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        arb_if.req  = 4'b0;
        tick();

        // Fixed priority starves the lower clients.
        arb_if.mode = 1'b1;
        arb_if.req  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            wait_grant("s2_fixed", {4'b1000, 2'd3, 1'b1, 1'b0});
            arb_if.done = 1'b1;
            tick();
            arb_if.done = 1'b0;
            check("s2_fixed_dead", outs(), 8'b0);
        end
        // Round-robin rotation starting after client 3.
        arb_if.mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_grant("s2_rr", {4'b0001 << i, 2'(i), 1'b1, 1'b0});
            arb_if.done = 1'b1;
            tick();
            arb_if.done = 1'b0;
            check("s2_rr_dead", outs(), 8'b0);
        end
        arb_if.req = 4'b0;
        tick();

        // Hold limit expiry.
        arb_if.req = 4'b0010;
        wait_grant("s3_grant", {4'b0010, 2'd1, 1'b1, 1'b0});
        repeat (3) begin
            tick();
            check("s3_hold", outs(), {4'b0010, 2'd1, 1'b1, 1'b0});
        end
        tick();
        check("s3_timeout", outs(), {4'b0000, 2'd0, 1'b0, 1'b1});
        tick();
        check("s3_regrant", outs(), {4'b0010, 2'd1, 1'b1, 1'b0});

        // done coinciding with the limit is a normal release.
        repeat (3) tick();
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        check("s4_done_at_limit", outs(), 8'b0);
        arb_if.req = 4'b0;
        tick();

        // Owner withdraws; pointer moves past it.
        arb_if.req = 4'b0100;
        wait_grant("s5_grant", {4'b0100, 2'd2, 1'b1, 1'b0});
        tick();
        arb_if.req = 4'b1011;
        tick();
        check("s5_withdraw", outs(), 8'b0);
        tick();
        check("s5_next", outs(), {4'b1000, 2'd3, 1'b1, 1'b0});
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        arb_if.req  = 4'b0;
        tick();

        // Move the pointer to 3, then reset asynchronously mid-grant.
        arb_if.req = 4'b0100;
        wait_grant("s6_pre", {4'b0100, 2'd2, 1'b1, 1'b0});
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        wait_grant("s6_regrant", {4'b0100, 2'd2, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 check("s6_async_reset", outs(), 8'b0);
        arb_if.req = 4'b1100;
        tick();
        rst_n = 1'b1;
        tick();
        check("s6_after_reset", outs(), {4'b0100, 2'd2, 1'b1, 1'b0});
        arb_if.done = 1'b1;
        tick();
        arb_if.done = 1'b0;
        arb_if.req  = 4'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester arbiter that shares one downstream resource (a single-port datapath, bus or encoder output) between four clients. It picks one owner per arbitration round, either by fixed priority (highest index wins, same convention as the team's priority encoders) or by round-robin. It holds the grant until the owner signals completion, withdraws its request, or exceeds a hold-time limit. It sits between the requesting clients and the shared resource's select/enable inputs.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may hold the grant; 0 disables the limit. Legal range 0–255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request vector; client i sets `req[i]` and holds it until it is granted and finished.
- `done`  in  1  single-cycle pulse from the current owner: transfer complete, release now. Ignored while idle.
- `mode`  in  1  0 = round-robin, 1 = fixed priority (`req[3]` highest). Sampled only at arbitration.
- `grant`  out  4  one-hot grant, registered; all-zero when idle.
- `grant_id`  out  2  binary index of the owner; 0 when idle.
- `busy`  out  1  1 while a grant is active; equals |`grant`.
- `timeout`  out  1  single-cycle pulse in the cycle `grant` drops because of the `MAX_HOLD` limit.

## Operation
- Two-state FSM: IDLE, BUSY. Registered state also includes `owner[1:0]`, the round-robin pointer `ptr[1:0]` and the hold counter `cnt[7:0]`.
- IDLE, `req`==0: stay in IDLE; outputs stay at reset values.
- IDLE, `req`!=0: select the winner, load `owner`, set `cnt`=1, go to BUSY.
- Winner when `mode`=1: highest set index of `req`.
- Winner when `mode`=0: first set bit scanning `ptr`, `ptr`+1, … modulo 4.
- BUSY release conditions are checked every cycle, in this priority:
  1. `done`=1.
  2. `req[owner]`=0 (withdrawn).
  3. `MAX_HOLD`!=0 and `cnt`==`MAX_HOLD`; this is the only case that pulses `timeout`.
- On release: go to IDLE; set `ptr` = `owner`+1 mod 4 in both modes; clear `cnt`.
- Otherwise in BUSY: `cnt` increments and saturates at 255.
- There is always one IDLE cycle between consecutive grants (dead cycle), even if requests are pending.
- `done` and `cnt`==`MAX_HOLD` in the same cycle: this is a normal release; `timeout` stays 0.
- Requests from non-owners during BUSY are not latched. They only compete at the next arbitration.
- A change of `mode` during BUSY does not affect the current owner.

## Timing
- Reset values: `grant`=0000, `grant_id`=00, `busy`=0, `timeout`=0; internally state=IDLE, `ptr`=0, `cnt`=0.
- Asserting `rst_n` low clears all of the above immediately, without waiting for a clock edge. A grant in progress is dropped.
- Grant latency: `req` sampled high at edge k gives `grant` high after edge k, i.e. 1 cycle.
- Release latency: `done` sampled at edge k gives `grant`=0 after edge k. The earliest next grant appears after edge k+1.
- Hold limit: with no `done` and no withdrawal, `grant` is high for exactly `MAX_HOLD` cycles. `timeout` is high in the following cycle, the first cycle with `grant`=0.
- `grant`, `grant_id`, `busy` and `timeout` are all driven directly from registers, with no combinational path from the inputs.

## Test plan
- Reset, then `req`=0101, `mode`=0: `grant`=0001 one cycle after `req` rises. `done` pulse: `grant`=0000 for one cycle, then 0100 with `grant_id`=2.
- `mode`=1, `req`=1111 held constant, `done` pulsed every grant: grant sequence is 1000, 1000, … (fixed priority starves the lower clients). Switch to `mode`=0: grants rotate 0001, 0010, 0100, 1000, with one dead cycle between grants.
- `MAX_HOLD`=4, `req`=0010 held constant, no `done`: `grant`=0010 for exactly 4 cycles, then `grant`=0 with `timeout`=1 for 1 cycle, then re-granted to client 1.
- `done` asserted in the same cycle as `cnt`==`MAX_HOLD`: release occurs with `timeout`=0.
- Owner drops `req[2]` mid-grant with no `done`: `grant` clears next cycle; `ptr` becomes 3, so with `req`=1011 the next grant is 1000.
- `rst_n` pulsed low mid-grant between clock edges: `grant` and `busy` go to 0 immediately. After release with `req`=1100, `mode`=0, the first grant is 0100 (`ptr`=0 scan).
